// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants and elaboration-time helpers for the adder-sharing arbiter slice.
package adder_share_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ID_WIDTH  = 2;
    localparam int DEF_IN1_WIDTH = 20;
    localparam int DEF_IN2_WIDTH = 32;
    localparam int DEF_OUT_WIDTH = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pointer value that gives requester 0 first priority after reset.
    function automatic int rr_reset_ptr(input int n);
        return n - 1;
    endfunction

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester-side and result-side handshake bundle between clients and the adder arbiter.
interface adder_share_arbiter_if
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int IN1_WIDTH = DEF_IN1_WIDTH,
    parameter int IN2_WIDTH = DEF_IN2_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*IN1_WIDTH-1:0] req_a;
    logic [NUM_REQ*IN2_WIDTH-1:0] req_b;
    logic                         out_valid;
    logic                         out_ready;
    logic [ID_WIDTH-1:0]          out_id;
    logic [OUT_WIDTH-1:0]         out_data;
    logic                         busy;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_id, out_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_id, out_data, busy
    );
endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_grant, ascending, wrapping.
module rr_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int LG_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LG_W-1:0]    last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [LG_W-1:0]    grant_id
);
    logic found_s;
    logic hit_s;
    int   idx_s;

    // Walk the NUM_REQ positions after last_grant and keep the first hit.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        idx_s    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx_s        = (int'(last_grant) + off) % NUM_REQ;
            hit_s        = en && !found_s && req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_id     = hit_s ? LG_W'(idx_s) : grant_id;
            found_s      = found_s | hit_s;
        end
    end
endmodule

// File: rtl/adder_share_arbiter_signed_adder.sv
// Shared fixed-point adder: sign-extend both operands to the widest width, add, keep OUT_WIDTH LSBs.
module signed_adder
    import adder_share_arbiter_pkg::*;
#(
    parameter string DTYPE           = "FXP",
    parameter string REGISTER_OUTPUT = "FALSE",
    parameter int    IN1_WIDTH       = DEF_IN1_WIDTH,
    parameter int    IN2_WIDTH       = DEF_IN2_WIDTH,
    parameter int    OUT_WIDTH       = DEF_OUT_WIDTH
) (
    input  logic signed [IN1_WIDTH-1:0] a,
    input  logic signed [IN2_WIDTH-1:0] b,
    output logic signed [OUT_WIDTH-1:0] out
);
    localparam int SUM_W = max3(IN1_WIDTH, IN2_WIDTH, OUT_WIDTH);

    logic signed [SUM_W-1:0] a_ext_s;
    logic signed [SUM_W-1:0] b_ext_s;
    logic signed [SUM_W-1:0] sum_s;

    assign a_ext_s = SUM_W'(a);
    assign b_ext_s = SUM_W'(b);
    assign sum_s   = a_ext_s + b_ext_s;

    // Only the unregistered fixed-point flavour exists; anything else drives zero.
    if (DTYPE == "FXP" && REGISTER_OUTPUT == "FALSE") begin : g_fxp_comb
        assign out = sum_s[OUT_WIDTH-1:0];
    end else begin : g_unsupported
        assign out = '0;
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one signed adder among NUM_REQ requesters, with a one-entry
// resettable result register that supports simultaneous drain and refill.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int IN1_WIDTH = DEF_IN1_WIDTH,
    parameter int IN2_WIDTH = DEF_IN2_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    adder_share_arbiter_if.slave  bus
);
    localparam int LG_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   grant_s;
    logic [LG_W-1:0]      grant_id_s;
    logic                 slot_free_s;
    logic                 accept_s;
    logic [IN1_WIDTH-1:0] a_sel_s;
    logic [IN2_WIDTH-1:0] b_sel_s;
    logic [OUT_WIDTH-1:0] sum_s;

    logic                 out_valid_q, out_valid_d;
    logic [ID_WIDTH-1:0]  out_id_q,    out_id_d;
    logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
    logic [LG_W-1:0]      last_grant_q, last_grant_d;

    assign slot_free_s = !out_valid_q || bus.out_ready;
    assign accept_s    = |(grant_s & bus.req_valid);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .en         (slot_free_s && !reset),
        .grant      (grant_s),
        .grant_id   (grant_id_s)
    );

    // One-hot AND-OR operand mux keyed by the grant vector.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sel_s = a_sel_s | (bus.req_a[i*IN1_WIDTH +: IN1_WIDTH] & {IN1_WIDTH{grant_s[i]}});
            b_sel_s = b_sel_s | (bus.req_b[i*IN2_WIDTH +: IN2_WIDTH] & {IN2_WIDTH{grant_s[i]}});
        end
    end

    signed_adder #(
        .DTYPE           ("FXP"),
        .REGISTER_OUTPUT ("FALSE"),
        .IN1_WIDTH       (IN1_WIDTH),
        .IN2_WIDTH       (IN2_WIDTH),
        .OUT_WIDTH       (OUT_WIDTH)
    ) u_signed_adder (
        .a   (a_sel_s),
        .b   (b_sel_s),
        .out (sum_s)
    );

    // Accept overwrites the slot even when it is draining; a lone drain only drops valid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_id_d     = ID_WIDTH'(grant_id_s);
            out_data_d   = sum_s;
            last_grant_d = grant_id_s;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result slot and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_data_q   <= '0;
            last_grant_q <= LG_W'(rr_reset_ptr(NUM_REQ));
        end else begin
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = out_valid_q | (|bus.req_valid);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: handshake order, backpressure, wrap, sign extension, reset.
module tb_adder_share_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    adder_share_arbiter_if bus_if ();

    adder_share_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [19:0] a, input logic [31:0] b);
        bus_if.req_a[i*20 +: 20] = a;
        bus_if.req_b[i*32 +: 32] = b;
    endtask

    initial begin
        int exp_id;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus_if.req_valid = 4'b0000;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        bus_if.out_ready = 1'b1;

        // Reset, with a request already presented
        set_ops(0, 20'd5, -32'sd7);
        bus_if.req_valid = 4'b0001;
        step();
        step();
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_out_id",    64'(bus_if.out_id),    64'd0);
        chk("rst_out_data",  64'(bus_if.out_data),  64'd0);
        chk("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
        chk("rst_busy",      64'(bus_if.busy),      64'd1);

        // Single request: 5 + -7
        reset = 1'b0;
        #1;
        chk("single_ready", 64'(bus_if.req_ready), 64'h1);
        step();
        bus_if.req_valid = 4'b0000;
        #1;
        chk("single_valid", 64'(bus_if.out_valid), 64'd1);
        chk("single_id",    64'(bus_if.out_id),    64'd0);
        chk("single_data",  64'(bus_if.out_data),  64'hFFFF_FFFE);
        step();
        chk("drain_valid", 64'(bus_if.out_valid), 64'd0);
        chk("drain_data_hold", 64'(bus_if.out_data), 64'hFFFF_FFFE);
        chk("idle_busy",   64'(bus_if.busy),      64'd0);

        // Fresh reset, then all four contending: order 0,1,2,3,0,1,2,3
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_ops(0, 20'd10, 32'd0);
        set_ops(1, 20'd20, 32'd1);
        set_ops(2, 20'd30, 32'd2);
        set_ops(3, 20'd40, 32'd3);
        bus_if.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_id = k % 4;
            chk("rr_ready", 64'(bus_if.req_ready), 64'(4'b0001 << exp_id));
            step();
            chk("rr_valid", 64'(bus_if.out_valid), 64'd1);
            chk("rr_id",    64'(bus_if.out_id),    64'(exp_id));
            chk("rr_data",  64'(bus_if.out_data),  64'(10 * (exp_id + 1) + exp_id));
        end
        bus_if.req_valid = 4'b0000;
        step();
        chk("rr_drain", 64'(bus_if.out_valid), 64'd0);

        // Backpressure on requester 2: 100 + -1, then 200 + 3 held off for five cycles
        bus_if.out_ready = 1'b0;
        set_ops(2, 20'd100, -32'sd1);
        bus_if.req_valid = 4'b0100;
        #1;
        chk("bp_first_ready", 64'(bus_if.req_ready), 64'h4);
        step();
        set_ops(2, 20'd200, 32'd3);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready_low", 64'(bus_if.req_ready), 64'h0);
            chk("bp_valid",     64'(bus_if.out_valid), 64'd1);
            chk("bp_id",        64'(bus_if.out_id),    64'd2);
            chk("bp_data",      64'(bus_if.out_data),  64'd99);
            step();
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus_if.req_ready), 64'h4);
        step();
        bus_if.req_valid = 4'b0000;
        #1;
        chk("bp_refill_valid", 64'(bus_if.out_valid), 64'd1);
        chk("bp_refill_data",  64'(bus_if.out_data),  64'd203);
        step();

        // Overflow wrap on requester 1; lone requester granted on consecutive cycles
        set_ops(1, 20'h7FFFF, 32'h7FFF_FFFF);
        bus_if.req_valid = 4'b0010;
        #1;
        chk("ovf_ready", 64'(bus_if.req_ready), 64'h2);
        step();
        chk("ovf_data", 64'(bus_if.out_data), 64'h8007_FFFE);
        chk("ovf_id",   64'(bus_if.out_id),   64'd1);
        chk("lone_ready_again", 64'(bus_if.req_ready), 64'h2);
        set_ops(1, 20'hFFFFF, 32'h8000_0000);
        step();
        chk("neg_wrap_data", 64'(bus_if.out_data), 64'h7FFF_FFFF);

        // Sign extension of a 20-bit negative operand on requester 3
        set_ops(3, 20'h80000, 32'd0);
        bus_if.req_valid = 4'b1000;
        #1;
        chk("sext_ready", 64'(bus_if.req_ready), 64'h8);
        step();
        chk("sext_data", 64'(bus_if.out_data), 64'hFFF8_0000);
        chk("sext_id",   64'(bus_if.out_id),   64'd3);
        bus_if.req_valid = 4'b0000;
        step();

        // Reset mid-stream with a held result and every requester pending
        bus_if.out_ready = 1'b0;
        bus_if.req_valid = 4'b1111;
        #1;
        chk("mid_pre_ready", 64'(bus_if.req_ready), 64'h1);
        step();
        chk("mid_pre_valid", 64'(bus_if.out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(bus_if.req_ready), 64'h0);
        step();
        chk("mid_rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("mid_rst_data",  64'(bus_if.out_data),  64'd0);
        reset = 1'b0;
        bus_if.out_ready = 1'b1;
        #1;
        chk("mid_restart_ready", 64'(bus_if.req_ready), 64'h1);
        step();
        chk("mid_restart_id",   64'(bus_if.out_id),   64'd0);
        chk("mid_restart_data", 64'(bus_if.out_data), 64'd10);
        bus_if.req_valid = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
